// File: rtl/tmds_channel_decoder_if.sv
// Serial TMDS input and decoded word outputs of one decoder channel.
// master = stimulus/driver side, slave = decoder side.
interface tmds_channel_decoder_if;
    logic       bit_in;
    logic       bit_valid;
    logic       word_valid;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       is_guard;
    logic       locked;
    logic       lock_lost;

    modport master (
        output bit_in, bit_valid,
        input  word_valid, data_out, ctrl_out, de, is_guard, locked, lock_lost
    );

    modport slave (
        input  bit_in, bit_valid,
        output word_valid, data_out, ctrl_out, de, is_guard, locked, lock_lost
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel receiver: deserialise, align on control tokens, decode 10b->8b; outputs 1 cycle after completing bit.
// No backpressure: idle bit_valid cycles simply stall all state.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int MAX_GAP    = 1024
) (
    input  logic                    clk,
    input  logic                    n_rst,
    tmds_channel_decoder_if.slave   bus
);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int GW  = $clog2(MAX_GAP + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t           state, state_n;
    logic [9:0]       win, win_n, win_shift;
    logic [3:0]       phase, phase_n, phase_adv;
    logic [MCW-1:0]   match_cnt, match_n;
    logic [GW-1:0]    gap, gap_n;
    logic             word_valid_r, word_valid_n;
    logic [7:0]       data_r, data_n;
    logic [1:0]       ctrl_r, ctrl_n;
    logic             de_r, de_n;
    logic             guard_r, guard_n;
    logic             locked_r, locked_n;
    logic             lost_r, lost_n;
    logic             is_tok, is_gd, boundary, emit;
    logic [1:0]       tok_ctrl;

    function automatic logic [7:0] decode(input logic [9:0] q);
        logic [7:0] m;
        logic [7:0] d;
        m    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = m[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        return d;
    endfunction

    assign win_shift = {bus.bit_in, win[9:1]};
    assign phase_adv = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
    assign boundary  = (phase_adv == 4'd9);

    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (win_shift)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_tok   = 1'b0;
        endcase
        is_gd = (win_shift == 10'b1011001100) || (win_shift == 10'b0100110011);
    end

    always_comb begin
        state_n      = state;
        win_n        = win;
        phase_n      = phase;
        match_n      = match_cnt;
        gap_n        = gap;
        word_valid_n = 1'b0;
        lost_n       = 1'b0;
        data_n       = data_r;
        ctrl_n       = ctrl_r;
        de_n         = de_r;
        guard_n      = guard_r;
        locked_n     = locked_r;
        emit         = 1'b0;

        if (bus.bit_valid) begin
            win_n   = win_shift;
            phase_n = phase_adv;
            case (state)
                SEARCH: begin
                    gap_n = '0;
                    if (is_tok) begin
                        // Any token position is taken as a word boundary.
                        phase_n = 4'd9;
                        match_n = MCW'(1);
                        if (LOCK_COUNT <= 1) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            emit     = 1'b1;
                        end else begin
                            state_n = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    gap_n = '0;
                    if (boundary) begin
                        if (!is_tok) begin
                            state_n = SEARCH;
                            match_n = '0;
                        end else if (int'(match_cnt) + 1 >= LOCK_COUNT) begin
                            match_n  = MCW'(LOCK_COUNT);
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            emit     = 1'b1;
                        end else begin
                            match_n = MCW'(int'(match_cnt) + 1);
                        end
                    end
                end
                default: begin
                    if (boundary) begin
                        if (is_tok) begin
                            gap_n = '0;
                            emit  = 1'b1;
                        end else if (int'(gap) + 1 >= MAX_GAP) begin
                            // Too long without a token: alignment is no longer trusted.
                            state_n  = SEARCH;
                            match_n  = '0;
                            gap_n    = '0;
                            locked_n = 1'b0;
                            lost_n   = 1'b1;
                            de_n     = 1'b0;
                            guard_n  = 1'b0;
                        end else begin
                            gap_n = GW'(int'(gap) + 1);
                            emit  = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (emit) begin
            word_valid_n = 1'b1;
            if (is_tok) begin
                de_n    = 1'b0;
                guard_n = 1'b0;
                ctrl_n  = tok_ctrl;
            end else if (is_gd) begin
                de_n    = 1'b0;
                guard_n = 1'b1;
            end else begin
                de_n    = 1'b1;
                guard_n = 1'b0;
                data_n  = decode(win_shift);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= SEARCH;
            win          <= '0;
            phase        <= '0;
            match_cnt    <= '0;
            gap          <= '0;
            word_valid_r <= 1'b0;
            data_r       <= '0;
            ctrl_r       <= '0;
            de_r         <= 1'b0;
            guard_r      <= 1'b0;
            locked_r     <= 1'b0;
            lost_r       <= 1'b0;
        end else begin
            state        <= state_n;
            win          <= win_n;
            phase        <= phase_n;
            match_cnt    <= match_n;
            gap          <= gap_n;
            word_valid_r <= word_valid_n;
            data_r       <= data_n;
            ctrl_r       <= ctrl_n;
            de_r         <= de_n;
            guard_r      <= guard_n;
            locked_r     <= locked_n;
            lost_r       <= lost_n;
        end
    end

    assign bus.word_valid = word_valid_r;
    assign bus.data_out   = data_r;
    assign bus.ctrl_out   = ctrl_r;
    assign bus.de         = de_r;
    assign bus.is_guard   = guard_r;
    assign bus.locked     = locked_r;
    assign bus.lock_lost  = lost_r;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder (LOCK_COUNT=8, MAX_GAP=1024).
module tb_tmds_channel_decoder;
    logic clk = 1'b0;
    logic n_rst;

    tmds_channel_decoder_if bus();

    tmds_channel_decoder #(.LOCK_COUNT(8), .MAX_GAP(1024)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wv_seen  = 0;
    int wv_mark  = 0;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] GB  = 10'b1011001100;
    localparam logic [9:0] D00 = 10'b0100000000;
    localparam logic [9:0] DFE = 10'b1011111111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.word_valid, bus.data_out, bus.ctrl_out, bus.de,
                    bus.is_guard, bus.locked, bus.lock_lost});
    endfunction

    task automatic idle_cycle();
        bus.bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int idle);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        if (bus.word_valid === 1'b1) wv_seen++;
        repeat (idle) idle_cycle();
    endtask

    // The last bit never idles so its strobe can be sampled straight after.
    task automatic send_word(input logic [9:0] q, input int max_idle);
        for (int i = 0; i < 10; i++)
            send_bit(q[i], (i == 9) ? 0 : int'($urandom_range(max_idle, 0)));
    endtask

    initial begin
        logic [9:0] w;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        n_rst         = 1'b0;

        // 1: reset with random inputs
        for (int c = 0; c < 5; c++) begin
            bus.bit_valid = 1'($urandom_range(1, 0));
            bus.bit_in    = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            chk("reset_outs", all_outs(), 32'h0);
        end
        bus.bit_valid = 1'b0;
        n_rst = 1'b1;
        idle_cycle();

        // 2: 3 junk bits + 8 tokens -> lock on bit 83
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        for (int t = 0; t < 7; t++) send_word(T00, 0);
        w = T00;
        for (int i = 0; i < 9; i++) send_bit(w[i], 0);
        chk("prelock_no_strobe", 32'(wv_seen), 32'd0);
        chk("prelock_locked", 32'(bus.locked), 32'd0);
        send_bit(w[9], 0);
        chk("lock_word_valid", 32'(bus.word_valid), 32'd1);
        chk("lock_locked", 32'(bus.locked), 32'd1);
        chk("lock_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("lock_de", 32'(bus.de), 32'd0);
        chk("lock_strobes", 32'(wv_seen), 32'd1);
        idle_cycle();
        chk("strobe_drops", 32'(bus.word_valid), 32'd0);

        // 3: data words
        send_word(D00, 0);
        chk("d00_valid", 32'(bus.word_valid), 32'd1);
        chk("d00_data", 32'(bus.data_out), 32'h00);
        chk("d00_de", 32'(bus.de), 32'd1);
        send_word(DFE, 0);
        chk("dfe_valid", 32'(bus.word_valid), 32'd1);
        chk("dfe_data", 32'(bus.data_out), 32'hFE);
        chk("dfe_de", 32'(bus.de), 32'd1);

        // 4: control tokens and guard band
        send_word(T01, 0);
        chk("t01_ctrl", 32'(bus.ctrl_out), 32'h1);
        chk("t01_de", 32'(bus.de), 32'd0);
        send_word(T11, 0);
        chk("t11_ctrl", 32'(bus.ctrl_out), 32'h3);
        send_word(GB, 0);
        chk("gb_valid", 32'(bus.word_valid), 32'd1);
        chk("gb_guard", 32'(bus.is_guard), 32'd1);
        chk("gb_de", 32'(bus.de), 32'd0);
        chk("gb_ctrl_hold", 32'(bus.ctrl_out), 32'h3);
        chk("gb_data_hold", 32'(bus.data_out), 32'hFE);

        // 5: gap timeout after 1024 data words, then relock
        send_word(T00, 0);
        chk("gap_tok_guard_clr", 32'(bus.is_guard), 32'd0);
        wv_mark = wv_seen;
        for (int n = 0; n < 1023; n++) send_word(D00, 0);
        chk("gap_1023_valid", 32'(bus.word_valid), 32'd1);
        chk("gap_1023_locked", 32'(bus.locked), 32'd1);
        chk("gap_1023_count", 32'(wv_seen - wv_mark), 32'd1023);
        send_word(D00, 0);
        chk("gap_drop_valid", 32'(bus.word_valid), 32'd0);
        chk("gap_drop_lost", 32'(bus.lock_lost), 32'd1);
        chk("gap_drop_locked", 32'(bus.locked), 32'd0);
        chk("gap_drop_de", 32'(bus.de), 32'd0);
        chk("gap_drop_data_hold", 32'(bus.data_out), 32'h00);
        idle_cycle();
        chk("lost_pulse_end", 32'(bus.lock_lost), 32'd0);
        wv_mark = wv_seen;
        for (int t = 0; t < 7; t++) send_word(T11, 0);
        chk("relock_pending", 32'(bus.locked), 32'd0);
        chk("relock_no_strobe", 32'(wv_seen - wv_mark), 32'd0);
        send_word(T11, 0);
        chk("relock_locked", 32'(bus.locked), 32'd1);
        chk("relock_ctrl", 32'(bus.ctrl_out), 32'h3);

        // 6: data words with random idle gaps, then mid-word reset
        send_word(D00, 4);
        chk("idle_d00_valid", 32'(bus.word_valid), 32'd1);
        chk("idle_d00_data", 32'(bus.data_out), 32'h00);
        chk("idle_d00_de", 32'(bus.de), 32'd1);
        repeat (3) idle_cycle();
        send_word(DFE, 4);
        chk("idle_dfe_valid", 32'(bus.word_valid), 32'd1);
        chk("idle_dfe_data", 32'(bus.data_out), 32'hFE);
        repeat (2) idle_cycle();
        chk("idle_hold_strobe", 32'(bus.word_valid), 32'd0);
        chk("idle_hold_data", 32'(bus.data_out), 32'hFE);
        w = DFE;
        for (int i = 0; i < 5; i++) send_bit(w[i], 0);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        n_rst         = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_outs", all_outs(), 32'h0);
        n_rst = 1'b1;
        bus.bit_valid = 1'b0;
        wv_mark = wv_seen;
        for (int i = 5; i < 10; i++) send_bit(w[i], 0);
        repeat (3) idle_cycle();
        chk("midreset_no_stray", 32'(wv_seen - wv_mark), 32'd0);
        chk("midreset_unlocked", 32'(bus.locked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
